// File: rtl/layer1_buf_pkg.sv
// -----------------------------------------------------------------------------
// layer1_buf_pkg
// Shared constants and state encoding for the layer1 buffer controller.
//   DEPTH : number of 128-bit words held by the layer1 SRAM
//   AW    : SRAM address width
//   DW    : SRAM data word width
// -----------------------------------------------------------------------------
package layer1_buf_pkg;

   localparam int DEPTH = 912;
   localparam int AW    = 10;
   localparam int DW    = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_e;

endpackage

// File: rtl/layer1_buf_ctrl.sv
// -----------------------------------------------------------------------------
// layer1_buf_ctrl
// Sequencing / arbitration controller for the dual-port layer1 SRAM wrapper.
// Port A takes the sequential write stream from the conv output stage, port B
// serves random reads from the layer2 fetch unit, limited to words already
// written so the two port addresses never collide.
//
// Ports
//   clk, rst              : clock, synchronous active-low reset
//   start, clear          : restart fill / return to idle (start wins)
//   wr_valid, wr_data     : write stream in, wr_ready accepts it
//   rd_req, rd_addr       : read request in, rd_gnt accepts it
//   rd_valid, rd_data     : read response, one cycle after rd_gnt
//   rd_err                : pulse for a request at or beyond DEPTH
//   fill_cnt, done        : words written since start, last-word pulse
//   sram_*                : wrapper strobes, addresses and data
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no writes, no reads granted
// FILL  | writes accepted at fill_cnt, reads granted below fill_cnt
// FULL  | all DEPTH words written, reads granted anywhere below DEPTH
// -----------------------------------------------------------------------------
module layer1_buf_ctrl
   import layer1_buf_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          clear,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_gnt,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_err,
   output logic [AW-1:0] fill_cnt,
   output logic          done,
   output logic          sram_OEA,
   output logic          sram_OEB,
   output logic          sram_WEAN,
   output logic          sram_WEBN,
   output logic [AW-1:0] sram_A,
   output logic [AW-1:0] sram_B,
   output logic [DW-1:0] sram_DIA,
   output logic [DW-1:0] sram_DIB,
   input  logic [DW-1:0] sram_DOB,
   input  logic [DW-1:0] sram_DOA
);

   state_e        state_q, state_d;
   logic [AW-1:0] fill_q, fill_d;
   logic          rd_valid_q, rd_valid_d;
   logic          done_q, done_d;
   logic          rd_err_q, rd_err_d;

   logic          wr_acc;
   logic          last_word;
   logic [AW-1:0] avail;
   logic          unused_doa;

   assign unused_doa = ^sram_DOA;

   // Strobes are gated with rst so the SRAM sees nothing while reset is held,
   // even before the synchronous reset has cleared the state register.
   assign wr_ready  = rst && (state_q == FILL) && !start && !clear;
   assign wr_acc    = wr_valid && wr_ready;
   assign last_word = (fill_q == AW'(DEPTH - 1));

   always_comb begin
      avail = '0;
      case (state_q)
         FILL:    avail = fill_q;
         FULL:    avail = AW'(DEPTH);
         default: avail = '0;
      endcase
   end

   // A granted read is strictly below fill_q while a write uses fill_q,
   // so port addresses differ whenever both ports are active.
   assign rd_gnt = rst && rd_req && (rd_addr < avail) && !start && !clear;

   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      rd_valid_d = rd_gnt;
      done_d     = wr_acc && last_word;
      rd_err_d   = rd_req && (rd_addr >= AW'(DEPTH));
      if (start) begin
         state_d = FILL;
         fill_d  = '0;
      end else if (clear) begin
         state_d = IDLE;
         fill_d  = '0;
      end else if (wr_acc) begin
         // fill_cnt saturates at DEPTH-1; FULL itself marks the final word
         if (last_word) state_d = FULL;
         else           fill_d  = fill_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fill_q     <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign fill_cnt  = fill_q;
   assign done      = done_q;
   assign rd_err    = rd_err_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = sram_DOB;

   assign sram_OEA  = 1'b0;
   assign sram_WEAN = !wr_acc;
   assign sram_A    = wr_acc ? fill_q : '0;
   assign sram_DIA  = wr_acc ? wr_data : '0;

   assign sram_OEB  = rd_gnt;
   assign sram_WEBN = 1'b1;
   assign sram_B    = rd_gnt ? rd_addr : '0;
   assign sram_DIB  = '0;

endmodule

// File: tb/tb_layer1_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layer1_buf_ctrl
// Directed bench for layer1_buf_ctrl with a behavioural SRAM on the wrapper
// pins. Granted reads push their expected word (data == address) into a
// scoreboard queue; a monitor pops and compares on every rd_valid.
// -----------------------------------------------------------------------------
module tb_layer1_buf_ctrl;
   import layer1_buf_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, clear;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt, rd_valid, rd_err, done;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] fill_cnt;
   logic          sram_OEA, sram_OEB, sram_WEAN, sram_WEBN;
   logic [AW-1:0] sram_A, sram_B;
   logic [DW-1:0] sram_DIA, sram_DIB, sram_DOB, sram_DOA;

   always #5 clk = ~clk;

   layer1_buf_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
      .fill_cnt(fill_cnt), .done(done),
      .sram_OEA(sram_OEA), .sram_OEB(sram_OEB),
      .sram_WEAN(sram_WEAN), .sram_WEBN(sram_WEBN),
      .sram_A(sram_A), .sram_B(sram_B),
      .sram_DIA(sram_DIA), .sram_DIB(sram_DIB),
      .sram_DOB(sram_DOB), .sram_DOA(sram_DOA)
   );

   // behavioural wrapper: write on WEAN low, one-cycle read on OEB
   logic [DW-1:0] mem [0:1023];
   assign sram_DOA = '0;
   always @(posedge clk) begin
      if (!sram_WEAN) mem[sram_A] <= sram_DIA;
      if (sram_OEB)   sram_DOB    <= mem[sram_B];
   end

   int checks = 0;
   int passes = 0;
   logic [DW-1:0] sb [$];

   int m_state = 0;   // 0 idle, 1 fill, 2 full
   int m_fill  = 0;
   int n_acc   = 0;
   int n_done  = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("rd_valid_unexpected", 1'b1, 1'b0);
         end else begin
            logic [DW-1:0] e;
            e = sb.pop_front();
            chk("rd_data", rd_data, e);
         end
      end
   end

   // Called at a negedge; drives inputs, checks combinational outputs,
   // crosses one rising edge and checks registered outputs at the next negedge.
   task automatic step(input logic wv, input int wd, input logic rq, input int ra,
                       input logic st, input logic cl);
      logic exp_wr, exp_gnt, acc, exp_done, exp_err;
      int   avail;
      wr_valid = wv;
      wr_data  = {96'd0, wd};
      rd_req   = rq;
      rd_addr  = ra[AW-1:0];
      start    = st;
      clear    = cl;
      #1;
      avail   = (m_state == 1) ? m_fill : (m_state == 2) ? DEPTH : 0;
      exp_wr  = rst && (m_state == 1) && !st && !cl;
      acc     = wv && exp_wr;
      exp_gnt = rst && rq && (ra < avail) && !st && !cl;
      chk("wr_ready", wr_ready, exp_wr);
      chk("rd_gnt", rd_gnt, exp_gnt);
      chk("sram_OEA", sram_OEA, 1'b0);
      chk("sram_WEBN", sram_WEBN, 1'b1);
      if (acc) begin
         chk("sram_WEAN", sram_WEAN, 1'b0);
         chk("sram_A", sram_A, m_fill);
         chk("sram_DIA", sram_DIA, {96'd0, wd});
         n_acc++;
      end else begin
         chk("sram_WEAN", sram_WEAN, 1'b1);
         chk("sram_A_idle", sram_A, 0);
      end
      if (exp_gnt) begin
         chk("sram_OEB", sram_OEB, 1'b1);
         chk("sram_B", sram_B, ra);
         sb.push_back({96'd0, ra});
      end else begin
         chk("sram_OEB", sram_OEB, 1'b0);
      end
      if (sram_WEAN === 1'b0 && sram_OEB === 1'b1)
         chk("a_ne_b", (sram_A != sram_B), 1'b1);
      exp_done = acc && (m_fill == DEPTH - 1);
      exp_err  = rst && rq && (ra >= DEPTH);
      if (!rst)          begin m_state = 0; m_fill = 0; end
      else if (st)       begin m_state = 1; m_fill = 0; end
      else if (cl)       begin m_state = 0; m_fill = 0; end
      else if (acc) begin
         if (m_fill == DEPTH - 1) m_state = 2;
         else                     m_fill++;
      end
      @(negedge clk);
      chk("done", done, exp_done);
      chk("rd_err", rd_err, exp_err);
      chk("rd_valid", rd_valid, exp_gnt);
      chk("fill_cnt", fill_cnt, m_fill);
      if (done === 1'b1) n_done++;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; clear = 1'b0; wr_valid = 1'b0;
      wr_data = '0; rd_req = 1'b0; rd_addr = '0;
      @(negedge clk);

      // reset held: strobes inactive even with requests present
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_fill", fill_cnt, 0);
      chk("rst_done", done, 1'b0);
      rst = 1'b1;
      step(1, 0, 1, 0, 0, 0);
      chk("idle_no_write", n_acc, 0);

      // fill with data == address, read hazards around fill_cnt 5..7
      step(0, 0, 0, 0, 1, 0);
      n_acc = 0; n_done = 0;
      for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0, 0);
      chk("fill_at_5", fill_cnt, 5);
      step(0, 0, 1, 5, 0, 0);
      chk("rd5_wait", rd_valid, 1'b0);
      step(1, 5, 1, 5, 0, 0);
      chk("rd5_wait2", rd_valid, 1'b0);
      step(1, 6, 1, 5, 0, 0);
      chk("rd5_valid", rd_valid, 1'b1);
      chk("rd5_data", rd_data, 5);
      wr_valid = 1'b1; wr_data = 7; rd_req = 1'b1; rd_addr = 6; #1;
      chk("same_cyc_WEAN", sram_WEAN, 1'b0);
      chk("same_cyc_A", sram_A, 7);
      chk("same_cyc_OEB", sram_OEB, 1'b1);
      chk("same_cyc_B", sram_B, 6);
      step(1, 7, 1, 6, 0, 0);
      chk("rd6_data", rd_data, 6);
      for (int i = 8; i < DEPTH; i++) step(1, i, 0, 0, 0, 0);
      chk("done_after_911", done, 1'b1);
      step(1, 999, 0, 0, 0, 0);
      chk("done_once", n_done, 1);
      chk("writes_912", n_acc, 912);
      chk("full_fill", fill_cnt, 911);
      chk("full_no_wr", wr_ready, 1'b0);

      // reads in FULL: last word and out-of-range
      step(0, 0, 1, 911, 0, 0);
      chk("rd911_data", rd_data, 911);
      step(0, 0, 1, 1000, 0, 0);
      chk("rd1000_err", rd_err, 1'b1);
      chk("rd1000_novalid", rd_valid, 1'b0);
      step(0, 0, 0, 0, 0, 0);
      chk("rd_err_pulse", rd_err, 1'b0);

      // start with a write pending at fill_cnt 300
      step(0, 0, 0, 0, 1, 0);
      n_done = 0;
      for (int i = 0; i < 300; i++) step(1, i, (i % 37) == 0, i / 2, 0, 0);
      chk("fill_at_300", fill_cnt, 300);
      step(1, 300, 1, 10, 1, 0);
      chk("start_fill0", fill_cnt, 0);
      chk("start_nodone", n_done, 0);

      // clear mid-fill
      for (int i = 0; i < 3; i++) step(1, i, 0, 0, 0, 0);
      step(1, 3, 1, 1, 0, 1);
      chk("clear_fill0", fill_cnt, 0);
      step(1, 0, 1, 0, 0, 0);
      chk("clear_idle", n_done, 0);

      // reset mid-fill at fill_cnt 100
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 100; i++) step(1, i, 0, 0, 0, 0);
      chk("fill_at_100", fill_cnt, 100);
      rst = 1'b0;
      step(1, 100, 1, 50, 0, 0);
      chk("rst_mid_fill0", fill_cnt, 0);
      chk("rst_mid_novalid", rd_valid, 1'b0);
      rst = 1'b1;
      step(1, 0, 1, 0, 0, 0);
      chk("rst_mid_idle", wr_ready, 1'b0);

      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/layer1_buf_ctrl.md
Name: layer1_buf_ctrl

Overview:
Sequencing and arbitration controller for the 912x128 dual-port layer1 SRAM wrapper. One requester, the layer1 conv output stage, streams words into port A at sequential addresses. A second requester, the layer2 fetch unit, issues random-address reads on port B. Reads are granted only for addresses already written. The controller guarantees the two port addresses differ whenever both ports are enabled, so the wrapper's same-address remap never fires. It also tracks fill level and signals layer completion.

Parameters:
DEPTH, 912, number of 128-bit words in the buffer
AW, 10, address width
DW, 128, data word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  pulse: clear fill pointer, enter FILL
clear  in  1  pulse: return to IDLE, fill pointer cleared
wr_valid  in  1  writer has a word
wr_data  in  DW  write word
wr_ready  out  1  controller accepts a write this cycle
rd_req  in  1  reader request
rd_addr  in  AW  read address
rd_gnt  out  1  read accepted this cycle
rd_valid  out  1  rd_data valid; one cycle after rd_gnt
rd_data  out  DW  read word, equal to sram_DOB
rd_err  out  1  registered pulse: request with rd_addr>=DEPTH
fill_cnt  out  AW  words written since start
done  out  1  registered 1-cycle pulse when word DEPTH-1 is written
sram_OEA, sram_OEB  out  1 each  wrapper output enables
sram_WEAN, sram_WEBN  out  1 each  wrapper write enables, active-low
sram_A, sram_B  out  AW each  wrapper addresses
sram_DIA, sram_DIB  out  DW each  wrapper write data
sram_DOB  in  DW  wrapper port-B read data
sram_DOA  in  DW  unused

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst.
- Reset: state=IDLE, fill_cnt=0, rd_valid=0, done=0, rd_err=0.
  - While in reset, all SRAM strobes are inactive: WEAN=1, WEBN=1, OEA=0, OEB=0.
  - Asserting reset mid-fill discards progress. There is no partial retention.
- States:
  - IDLE: wr_ready=0, rd_gnt=0.
  - FILL: accepts writes; grants reads.
  - FULL: no writes; grants reads.
- Transitions:
  - start in any state -> FILL, fill_cnt<=0. start has priority over clear and over any write in that cycle.
  - clear (no start) -> IDLE, fill_cnt<=0.
  - FILL with an accepted write while fill_cnt==DEPTH-1 -> FULL, done<=1.
- Write path:
  - wr_ready = (state==FILL) && !start && !clear.
  - Accepted write (wr_valid&&wr_ready): same cycle WEAN=0, A=fill_cnt, DIA=wr_data. fill_cnt increments next cycle.
  - Otherwise WEAN=1, A=0, DIA=0.
  - OEA=0 always.
- Read path:
  - avail = fill_cnt in FILL, DEPTH in FULL, 0 in IDLE.
  - rd_gnt = rd_req && rd_addr<avail && !start && !clear. Combinational, same cycle.
  - On grant: OEB=1, B=rd_addr. Otherwise OEB=0, B=0.
  - WEBN=1 and DIB=0 always.
  - rd_valid <= rd_gnt. rd_data is a passthrough of sram_DOB, giving latency 1.
  - An ungranted request holds; the reader keeps rd_req and rd_addr stable until granted.
  - rd_addr>=DEPTH is never granted; rd_err <= 1 for one cycle per such request cycle.
- Hazard guarantee:
  - A granted read has rd_addr<fill_cnt, and a write that cycle uses A=fill_cnt.
  - Therefore A!=B whenever WEAN=0 and OEB=1, including read-after-write of the word just written. That word becomes readable the cycle after it is written.
- Simultaneous events:
  - Write plus read in the same cycle: both proceed.
  - start with rd_req: no grant that cycle.
  - fill_cnt saturates: no writes are possible in FULL.
- done asserts exactly once per fill. It does not assert if clear or start arrives before the final word.

Decomposition:
- Shared package layer1_buf_pkg holds:
  - DEPTH, AW, DW constants.
  - State enum typedef {IDLE, FILL, FULL}.
- No sub-module is required. The controller is a single FSM plus fill counter. The top level instantiates it beside layer1_wrapper.

Test Plan:
- Reset then start, 912 back-to-back writes of data=address -> 912 wr_ready cycles, done pulses once on the cycle after write 911, state FULL, fill_cnt=911.
- During FILL with fill_cnt=5, rd_addr=5 -> rd_gnt=0 until write 5 lands; granted the next cycle; rd_valid one cycle later with rd_data=5.
- Same-cycle write to addr 7 and read of addr 6 -> WEAN=0 with A=7, OEB=1 with B=6, A!=B; next cycle rd_data=6.
- In FULL, rd_addr=911 -> granted with rd_data=911. rd_addr=1000 -> no grant, rd_err pulse, rd_valid=0.
- start asserted with wr_valid at fill_cnt=300 -> write rejected, fill_cnt=0 next cycle, no done.
- rst low mid-fill at fill_cnt=100 -> next cycle IDLE, fill_cnt=0, all strobes inactive, rd_valid=0.
